// File: rtl/fc_sched.sv
// fc_sched: sequences one FC layer pass, splitting the index stream into
// chunks that ping-pong through two index buffers ahead of the FC AGU.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_vld/cfg_rdy   layer config handshake (cfg_mode, cfg_total, cfg_is_new)
//   ld_req/ld_ack     index loader request (ld_buf, ld_len), ld_done completion
//   agu_start         AGU start pulse with agu_mode/agu_idx_cnt/agu_is_new/agu_buf_sel
//   agu_done          AGU done level
//   busy, layer_done  layer in progress, end-of-layer pulse
module fc_sched #(
  parameter int TOT_W     = 16,
  parameter int CHUNK_MAX = 256,
  parameter int DRAIN_LAT = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_vld,
  output logic             cfg_rdy,
  input  logic [1:0]       cfg_mode,
  input  logic [TOT_W-1:0] cfg_total,
  input  logic             cfg_is_new,
  output logic             ld_req,
  input  logic             ld_ack,
  output logic             ld_buf,
  output logic [8:0]       ld_len,
  input  logic             ld_done,
  output logic             agu_start,
  output logic [1:0]       agu_mode,
  output logic [7:0]       agu_idx_cnt,
  output logic             agu_is_new,
  output logic             agu_buf_sel,
  input  logic             agu_done,
  output logic             busy,
  output logic             layer_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_START, S_RUN, S_DRAIN, S_FIN
  } st_t;

  typedef enum logic [1:0] {
    B_EMPTY, B_LOADING, B_FULL
  } bst_t;

  localparam int DW = $clog2(DRAIN_LAT + 1);
  localparam logic [TOT_W-1:0] CMAX_T = TOT_W'(CHUNK_MAX);
  localparam logic [8:0]       CMAX_L = 9'(CHUNK_MAX);
  localparam logic [DW-1:0]    DLAST  = DW'(DRAIN_LAT - 1);

  st_t              st;
  bst_t             bst [2];
  logic [8:0]       blen [2];
  logic [TOT_W-1:0] load_rem;
  logic [TOT_W-1:0] run_rem;
  logic             run_buf;
  logic             ld_ptr;
  logic             is_new_q;
  logic             first;
  logic             run_first;
  logic [DW-1:0]    dcnt;

  logic             any_loading;
  logic [8:0]       next_len;
  logic [8:0]       cur_len;

  assign any_loading = (bst[0] == B_LOADING) || (bst[1] == B_LOADING);
  assign next_len    = (load_rem > CMAX_T) ? CMAX_L : 9'(load_rem);
  assign cur_len     = blen[run_buf];

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_IDLE;
      bst[0]      <= B_EMPTY;
      bst[1]      <= B_EMPTY;
      blen[0]     <= '0;
      blen[1]     <= '0;
      load_rem    <= '0;
      run_rem     <= '0;
      run_buf     <= 1'b0;
      ld_ptr      <= 1'b0;
      is_new_q    <= 1'b0;
      first       <= 1'b0;
      run_first   <= 1'b0;
      dcnt        <= '0;
      cfg_rdy     <= 1'b1;
      ld_req      <= 1'b0;
      ld_buf      <= 1'b0;
      ld_len      <= '0;
      agu_start   <= 1'b0;
      agu_mode    <= '0;
      agu_idx_cnt <= '0;
      agu_is_new  <= 1'b0;
      agu_buf_sel <= 1'b0;
      busy        <= 1'b0;
      layer_done  <= 1'b0;
    end else begin
      // Loader side: one request in flight, buffers filled alternately.
      if (ld_req && ld_ack) begin
        ld_req       <= 1'b0;
        load_rem     <= load_rem - TOT_W'(ld_len);
        bst[ld_buf]  <= B_LOADING;
        blen[ld_buf] <= ld_len;
        ld_ptr       <= ~ld_ptr;
      end else if (!ld_req && !any_loading && load_rem != '0 &&
                   bst[ld_ptr] == B_EMPTY) begin
        ld_req <= 1'b1;
        ld_buf <= ld_ptr;
        ld_len <= next_len;
      end

      // Completion lands on whichever buffer is loading; stray pulses drop.
      if (ld_done) begin
        if (bst[0] == B_LOADING)
          bst[0] <= B_FULL;
        else if (bst[1] == B_LOADING)
          bst[1] <= B_FULL;
      end

      case (st)
        S_IDLE: begin
          if (cfg_vld) begin
            cfg_rdy  <= 1'b0;
            busy     <= 1'b1;
            agu_mode <= cfg_mode;
            is_new_q <= cfg_is_new;
            first    <= 1'b1;
            run_buf  <= 1'b0;
            ld_ptr   <= 1'b0;
            if (cfg_total == '0) begin
              st         <= S_FIN;
              layer_done <= 1'b1;
            end else begin
              st       <= S_WAIT;
              load_rem <= cfg_total;
              run_rem  <= cfg_total;
            end
          end
        end
        S_WAIT: begin
          if (bst[run_buf] == B_FULL) begin
            st          <= S_START;
            agu_start   <= 1'b1;
            agu_idx_cnt <= 8'(cur_len - 9'd1);
            agu_buf_sel <= run_buf;
            agu_is_new  <= first & is_new_q;
          end
        end
        S_START: begin
          st        <= S_RUN;
          agu_start <= 1'b0;
          first     <= 1'b0;
          run_first <= 1'b1;
        end
        S_RUN: begin
          // agu_done is still stale high in the first RUN cycle.
          if (run_first) begin
            run_first <= 1'b0;
          end else if (agu_done) begin
            st   <= S_DRAIN;
            dcnt <= '0;
          end
        end
        S_DRAIN: begin
          if (dcnt == DLAST) begin
            bst[run_buf] <= B_EMPTY;
            run_buf      <= ~run_buf;
            run_rem      <= run_rem - TOT_W'(cur_len);
            if (run_rem == TOT_W'(cur_len)) begin
              st         <= S_FIN;
              layer_done <= 1'b1;
            end else begin
              st <= S_WAIT;
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        S_FIN: begin
          st         <= S_IDLE;
          layer_done <= 1'b0;
          busy       <= 1'b0;
          cfg_rdy    <= 1'b1;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_sched.sv
// tb_fc_sched: directed bench for fc_sched with a loader/AGU responder
// that logs every request and start for per-test checks.
module tb_fc_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_vld;
  logic        cfg_rdy;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_total;
  logic        cfg_is_new;
  logic        ld_req;
  logic        ld_ack;
  logic        ld_buf;
  logic [8:0]  ld_len;
  logic        ld_done;
  logic        agu_start;
  logic [1:0]  agu_mode;
  logic [7:0]  agu_idx_cnt;
  logic        agu_is_new;
  logic        agu_buf_sel;
  logic        agu_done;
  logic        busy;
  logic        layer_done;

  fc_sched dut (
    .clk(clk), .rst(rst),
    .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
    .cfg_mode(cfg_mode), .cfg_total(cfg_total),
    .cfg_is_new(cfg_is_new),
    .ld_req(ld_req), .ld_ack(ld_ack),
    .ld_buf(ld_buf), .ld_len(ld_len),
    .ld_done(ld_done),
    .agu_start(agu_start), .agu_mode(agu_mode),
    .agu_idx_cnt(agu_idx_cnt), .agu_is_new(agu_is_new),
    .agu_buf_sel(agu_buf_sel), .agu_done(agu_done),
    .busy(busy), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int done_delay = 0;
  bit agu_hold = 1'b1;
  int run_len = 3;

  int n_ld, n_st, n_ldone;
  int ld_len_l [8];
  int ld_buf_l [8];
  int ld_cyc_l [8];
  int st_idx_l [8];
  int st_new_l [8];
  int st_sel_l [8];
  int st_cyc_l [8];
  int ldone_cyc;
  bit pend;
  int dcnt;
  int arun;

  // Loader and AGU responder, acting on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      ld_ack   = 1'b0;
      ld_done  = 1'b0;
      pend     = 1'b0;
      arun     = 0;
      agu_done = 1'b1;
    end else begin
      ld_done = 1'b0;
      if (pend) begin
        if (dcnt == 0) begin
          ld_done = 1'b1;
          pend    = 1'b0;
        end else begin
          dcnt = dcnt - 1;
        end
      end
      if (ld_ack) begin
        ld_ack = 1'b0;
      end else if (ld_req) begin
        ld_ack = 1'b1;
        pend   = 1'b1;
        dcnt   = done_delay;
        if (n_ld < 8) begin
          ld_len_l[n_ld] = int'(ld_len);
          ld_buf_l[n_ld] = int'(ld_buf);
          ld_cyc_l[n_ld] = cyc;
        end
        n_ld = n_ld + 1;
      end
      if (agu_start) begin
        if (n_st < 8) begin
          st_idx_l[n_st] = int'(agu_idx_cnt);
          st_new_l[n_st] = int'(agu_is_new);
          st_sel_l[n_st] = int'(agu_buf_sel);
          st_cyc_l[n_st] = cyc;
        end
        n_st = n_st + 1;
        if (!agu_hold) arun = run_len;
      end else if (arun > 0) begin
        agu_done = 1'b0;
        arun     = arun - 1;
      end else begin
        agu_done = 1'b1;
      end
      if (layer_done) begin
        n_ldone   = n_ldone + 1;
        ldone_cyc = cyc;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    n_ld    = 0;
    n_st    = 0;
    n_ldone = 0;
  endtask

  task automatic start_layer(input int total, input bit nw,
                             input logic [1:0] md);
    int t;
    t = 0;
    while (!cfg_rdy && t < 200) begin
      step();
      t++;
    end
    checks++;
    if (cfg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL cfg_rdy_wait got %b want 1", cfg_rdy);
    end
    cfg_vld    = 1'b1;
    cfg_total  = 16'(total);
    cfg_is_new = nw;
    cfg_mode   = md;
    step();
    cfg_vld = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int t;
    t = 0;
    while (n_ldone == 0 && t < bound) begin
      step();
      t++;
    end
    step(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    checks++;
    if (cfg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_cfg_rdy got %b want 1", cfg_rdy);
    end
    checks++;
    if ({busy, ld_req, agu_start, layer_done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0000",
               {busy, ld_req, agu_start, layer_done});
    end
    checks++;
    if ({ld_len, agu_idx_cnt, agu_mode} !== 19'd0) begin
      errors++;
      $display("FAIL reset_data got %0d/%0d/%0d want 0/0/0",
               ld_len, agu_idx_cnt, agu_mode);
    end
  endtask

  task automatic test_single();
    agu_hold   = 1'b1;
    done_delay = 0;
    clear_logs();
    start_layer(100, 1'b1, 2'd2);
    checks++;
    if (busy !== 1'b1 || agu_mode !== 2'd2) begin
      errors++;
      $display("FAIL single_accept got busy=%b mode=%0d want 1/2",
               busy, agu_mode);
    end
    wait_done(500);
    checks++;
    if (n_ld !== 1 || ld_len_l[0] !== 100 || ld_buf_l[0] !== 0) begin
      errors++;
      $display("FAIL single_load got n=%0d len=%0d buf=%0d want 1/100/0",
               n_ld, ld_len_l[0], ld_buf_l[0]);
    end
    checks++;
    if (n_st !== 1 || st_idx_l[0] !== 99 || st_new_l[0] !== 1 ||
        st_sel_l[0] !== 0) begin
      errors++;
      $display("FAIL single_start got n=%0d idx=%0d new=%0d sel=%0d want 1/99/1/0",
               n_st, st_idx_l[0], st_new_l[0], st_sel_l[0]);
    end
    checks++;
    if (n_ldone !== 1) begin
      errors++;
      $display("FAIL single_done_cnt got %0d want 1", n_ldone);
    end
    // START, two RUN cycles, 12 DRAIN cycles, then FIN.
    checks++;
    if (ldone_cyc - st_cyc_l[0] !== 15) begin
      errors++;
      $display("FAIL single_timing got %0d want 15",
               ldone_cyc - st_cyc_l[0]);
    end
    checks++;
    if (cfg_rdy !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got rdy=%b busy=%b want 1/0",
               cfg_rdy, busy);
    end
  endtask

  task automatic test_chunks();
    agu_hold   = 1'b0;
    run_len    = 3;
    done_delay = 0;
    clear_logs();
    start_layer(600, 1'b1, 2'd1);
    wait_done(2000);
    checks++;
    if (n_ld !== 3 || ld_len_l[0] !== 256 || ld_len_l[1] !== 256 ||
        ld_len_l[2] !== 88) begin
      errors++;
      $display("FAIL chunks_len got n=%0d %0d,%0d,%0d want 3 256,256,88",
               n_ld, ld_len_l[0], ld_len_l[1], ld_len_l[2]);
    end
    checks++;
    if (ld_buf_l[0] !== 0 || ld_buf_l[1] !== 1 || ld_buf_l[2] !== 0) begin
      errors++;
      $display("FAIL chunks_buf got %0d,%0d,%0d want 0,1,0",
               ld_buf_l[0], ld_buf_l[1], ld_buf_l[2]);
    end
    checks++;
    if (n_st !== 3 || st_idx_l[0] !== 255 || st_idx_l[1] !== 255 ||
        st_idx_l[2] !== 87) begin
      errors++;
      $display("FAIL chunks_idx got n=%0d %0d,%0d,%0d want 3 255,255,87",
               n_st, st_idx_l[0], st_idx_l[1], st_idx_l[2]);
    end
    checks++;
    if (st_new_l[0] !== 1 || st_new_l[1] !== 0 || st_new_l[2] !== 0) begin
      errors++;
      $display("FAIL chunks_is_new got %0d,%0d,%0d want 1,0,0",
               st_new_l[0], st_new_l[1], st_new_l[2]);
    end
    checks++;
    if (st_sel_l[0] !== 0 || st_sel_l[1] !== 1 || st_sel_l[2] !== 0) begin
      errors++;
      $display("FAIL chunks_sel got %0d,%0d,%0d want 0,1,0",
               st_sel_l[0], st_sel_l[1], st_sel_l[2]);
    end
    // Buffer 0 must drain (>= 4 RUN + 12 DRAIN cycles) before reload.
    checks++;
    if (ld_cyc_l[2] <= st_cyc_l[0] + 16) begin
      errors++;
      $display("FAIL chunks_reuse got reload@%0d start0@%0d want gap>16",
               ld_cyc_l[2], st_cyc_l[0]);
    end
    checks++;
    if (n_ldone !== 1) begin
      errors++;
      $display("FAIL chunks_done_cnt got %0d want 1", n_ldone);
    end
  endtask

  task automatic test_slow_loader();
    agu_hold   = 1'b0;
    run_len    = 2;
    done_delay = 300;
    clear_logs();
    start_layer(300, 1'b0, 2'd3);
    wait_done(3000);
    checks++;
    if (n_ld !== 2 || ld_buf_l[0] !== 0 || ld_buf_l[1] !== 1 ||
        ld_len_l[1] !== 44) begin
      errors++;
      $display("FAIL slow_load got n=%0d buf=%0d,%0d len1=%0d want 2 0,1 44",
               n_ld, ld_buf_l[0], ld_buf_l[1], ld_len_l[1]);
    end
    checks++;
    if (st_cyc_l[0] - ld_cyc_l[0] < 300) begin
      errors++;
      $display("FAIL slow_wait0 got gap %0d want >=300",
               st_cyc_l[0] - ld_cyc_l[0]);
    end
    checks++;
    if (st_cyc_l[1] - ld_cyc_l[1] < 300) begin
      errors++;
      $display("FAIL slow_wait1 got gap %0d want >=300",
               st_cyc_l[1] - ld_cyc_l[1]);
    end
    checks++;
    if (n_st !== 2 || st_idx_l[0] !== 255 || st_idx_l[1] !== 43 ||
        st_new_l[0] !== 0 || st_sel_l[1] !== 1) begin
      errors++;
      $display("FAIL slow_start got n=%0d idx=%0d,%0d new0=%0d sel1=%0d want 2 255,43 0 1",
               n_st, st_idx_l[0], st_idx_l[1], st_new_l[0], st_sel_l[1]);
    end
    checks++;
    if (n_ldone !== 1) begin
      errors++;
      $display("FAIL slow_done_cnt got %0d want 1", n_ldone);
    end
    done_delay = 0;
  endtask

  task automatic test_zero();
    clear_logs();
    start_layer(0, 1'b1, 2'd0);
    checks++;
    if (layer_done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_done got done=%b busy=%b want 1/1",
               layer_done, busy);
    end
    step();
    checks++;
    if (layer_done !== 1'b0 || cfg_rdy !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_after got done=%b rdy=%b busy=%b want 0/1/0",
               layer_done, cfg_rdy, busy);
    end
    step(5);
    checks++;
    if (n_ld !== 0 || n_st !== 0 || n_ldone !== 1) begin
      errors++;
      $display("FAIL zero_quiet got ld=%0d st=%0d done=%0d want 0/0/1",
               n_ld, n_st, n_ldone);
    end
  endtask

  task automatic test_mid_reset();
    int t;
    agu_hold   = 1'b0;
    run_len    = 3;
    done_delay = 0;
    clear_logs();
    start_layer(600, 1'b1, 2'd1);
    t = 0;
    while (n_st < 2 && t < 2000) begin
      step();
      t++;
    end
    checks++;
    if (n_st !== 2) begin
      errors++;
      $display("FAIL midrst_reach got starts=%0d want 2", n_st);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (cfg_rdy !== 1'b1 || busy !== 1'b0 || ld_req !== 1'b0 ||
        agu_start !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state got rdy=%b busy=%b req=%b start=%b want 1/0/0/0",
               cfg_rdy, busy, ld_req, agu_start);
    end
    agu_hold = 1'b1;
    clear_logs();
    start_layer(100, 1'b0, 2'd2);
    wait_done(500);
    checks++;
    if (n_ld !== 1 || ld_len_l[0] !== 100 || ld_buf_l[0] !== 0) begin
      errors++;
      $display("FAIL midrst_load got n=%0d len=%0d buf=%0d want 1/100/0",
               n_ld, ld_len_l[0], ld_buf_l[0]);
    end
    checks++;
    if (n_st !== 1 || st_idx_l[0] !== 99 || st_new_l[0] !== 0 ||
        st_sel_l[0] !== 0 || n_ldone !== 1) begin
      errors++;
      $display("FAIL midrst_run got st=%0d idx=%0d new=%0d sel=%0d done=%0d want 1/99/0/0/1",
               n_st, st_idx_l[0], st_new_l[0], st_sel_l[0], n_ldone);
    end
  endtask

  initial begin
    rst        = 1'b1;
    cfg_vld    = 1'b0;
    cfg_mode   = '0;
    cfg_total  = '0;
    cfg_is_new = 1'b0;
    clear_logs();
    test_reset();
    test_single();
    test_chunks();
    test_slow_loader();
    test_zero();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
